// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 slice loader: pixel and bundle layout plus sweep FSM states.
package hub75_pkg;

  localparam int unsigned RGB_RES  = 9;
  localparam int unsigned NUM_COLS = 64;

  typedef logic [RGB_RES-1:0]    pixel_t;
  typedef pixel_t [NUM_COLS-1:0] half_column_t;
  typedef half_column_t [1:0]    column_bundle_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HANDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/mem_read_pipe.sv
// Tags frame-memory returns: a LATENCY-deep valid/index shift register aligned with the memory read latency.
module mem_read_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned IDX_W   = 7
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             ret_valid,
  output logic [IDX_W-1:0] ret_idx
);

  logic [LATENCY-1:0] vld;
  logic [IDX_W-1:0]   idx [LATENCY];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) idx[i] <= '0;
    end else begin
      vld[0] <= issue_valid;
      idx[0] <= issue_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign ret_valid = vld[LATENCY-1];
  assign ret_idx   = idx[LATENCY-1];

endmodule

// File: rtl/hub75_slice_loader.sv
// Sweeps all scan rows of a requested angular slice from frame memory into double-buffered
// 2 x NUM_COLS pixel bundles handed to the HUB75 column driver over a valid/ready stream.
module hub75_slice_loader #(
  parameter  int unsigned ROTATIONAL_RES = 1024,
  parameter  int unsigned NUM_COLS       = hub75_pkg::NUM_COLS,
  parameter  int unsigned SCAN_RATE      = 32,
  parameter  int unsigned RGB_RES        = hub75_pkg::RGB_RES,
  parameter  int unsigned MEM_LATENCY    = 2,
  localparam int unsigned TW             = $clog2(ROTATIONAL_RES),
  localparam int unsigned SW             = $clog2(SCAN_RATE),
  localparam int unsigned PW             = $clog2(NUM_COLS),
  localparam int unsigned AW             = TW + SW + 1 + PW
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [TW-1:0]                           theta_in,
  input  logic                                    theta_valid_in,
  output logic [AW-1:0]                           mem_addr,
  output logic                                    mem_en,
  input  logic [RGB_RES-1:0]                      mem_data,
  output logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]   column_data,
  output logic [SW-1:0]                           col_index,
  output logic                                    tvalid,
  input  logic                                    tready,
  output logic                                    busy,
  output logic [7:0]                              drop_count
);
  import hub75_pkg::*;

  localparam int unsigned IW = PW + 1;
  localparam logic [IW:0]   ISSUE_END = (IW+1)'(2 * NUM_COLS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(2 * NUM_COLS - 1);
  localparam logic [SW-1:0] LAST_ROW  = SW'(SCAN_RATE - 1);

  typedef logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] bundle_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   theta_cur, pend_theta, start_theta;
  logic            pend_valid;
  logic [SW-1:0]   scan_row;
  logic [IW:0]     issue_cnt;
  logic            ret_valid;
  logic [IW-1:0]   ret_idx;
  bundle_t         bank [2];
  logic            fill_ptr;
  logic            out_free, swap, start_new, last_row, last_ret, final_ho;
  logic            pend_store, drop_inc;

  mem_read_pipe #(
    .LATENCY (MEM_LATENCY),
    .IDX_W   (IW)
  ) u_read_pipe (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .issue_valid (mem_en),
    .issue_idx   (issue_cnt[IW-1:0]),
    .ret_valid   (ret_valid),
    .ret_idx     (ret_idx)
  );

  assign out_free = !tvalid || tready;
  assign last_row = (scan_row == LAST_ROW);
  assign last_ret = ret_valid && (ret_idx == LAST_IDX);
  assign final_ho = (state == ST_HANDOFF) && out_free && last_row;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    swap        = 1'b0;
    start_new   = 1'b0;
    start_theta = theta_in;
    unique case (state)
      ST_IDLE: begin
        if (theta_valid_in) begin
          start_new = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_en = (issue_cnt != ISSUE_END);
        if (last_ret) state_nxt = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (out_free) begin
          swap = 1'b1;
          // A request landing on the final handoff outranks the pending slot
          if (!last_row) begin
            state_nxt = ST_FETCH;
          end else if (theta_valid_in) begin
            start_new = 1'b1;
            state_nxt = ST_FETCH;
          end else if (pend_valid) begin
            start_new   = 1'b1;
            start_theta = pend_theta;
            state_nxt   = ST_FETCH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_store = theta_valid_in && (state != ST_IDLE) && !final_ho;
    drop_inc   = theta_valid_in && (state != ST_IDLE) && pend_valid;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      theta_cur  <= '0;
      pend_theta <= '0;
      pend_valid <= 1'b0;
      scan_row   <= '0;
      issue_cnt  <= '0;
      bank[0]    <= '0;
      bank[1]    <= '0;
      fill_ptr   <= 1'b0;
      col_index  <= '0;
      tvalid     <= 1'b0;
      drop_count <= '0;
    end else begin
      if (start_new) theta_cur <= start_theta;

      if (final_ho)        pend_valid <= 1'b0;
      else if (pend_store) pend_valid <= 1'b1;
      if (pend_store) pend_theta <= theta_in;

      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

      if (last_ret)    issue_cnt <= '0;
      else if (mem_en) issue_cnt <= issue_cnt + 1'b1;

      if (ret_valid) bank[fill_ptr][ret_idx[PW]][ret_idx[PW-1:0]] <= mem_data;

      if (swap) begin
        fill_ptr  <= ~fill_ptr;
        col_index <= scan_row;
        scan_row  <= last_row ? '0 : scan_row + 1'b1;
      end

      tvalid <= swap || (tvalid && !tready);
    end
  end

  assign column_data = bank[~fill_ptr];
  assign mem_addr    = mem_en ? {theta_cur, scan_row, issue_cnt[IW-1:0]} : '0;
  assign busy        = (state != ST_IDLE);

endmodule
